// File: rtl/redmule_exp_mc_buffer_if.sv
// Stream interface of the exponent prefetch buffer: one packed-beat input
// stream, one N_LANES-wide output stream, replay controls and the occupancy
// counter. The buffer attaches through the slave modport and the exponent
// streamer/consumer side through the master modport.
// Optional feature macro: REDMULE_EXP_BUF_REPLAY_EN adds mark_i/rewind_i.
interface redmule_exp_mc_buffer_if #(
   parameter int unsigned EXP_WIDTH  = 8,
   parameter int unsigned BEAT_WIDTH = 512,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned N_LANES    = 4
);
   localparam int unsigned EPB = BEAT_WIDTH / EXP_WIDTH;
   localparam int unsigned ICW = $clog2(EPB + 1);
   localparam int unsigned OCW = $clog2(N_LANES + 1);
   localparam int unsigned PW  = $clog2(DEPTH) + 1;

   logic                         in_valid_i;
   logic                         in_ready_o;
   logic [BEAT_WIDTH-1:0]        in_data_i;
   logic [ICW-1:0]               in_cnt_i;
   logic                         in_last_i;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic [N_LANES*EXP_WIDTH-1:0] out_data_o;
   logic [OCW-1:0]               out_cnt_o;
   logic                         out_last_o;
   logic [PW-1:0]                occupancy_o;
`ifdef REDMULE_EXP_BUF_REPLAY_EN
   logic                         mark_i;
   logic                         rewind_i;
`endif

   modport slave (
`ifdef REDMULE_EXP_BUF_REPLAY_EN
      input  mark_i, rewind_i,
`endif
      input  in_valid_i, in_data_i, in_cnt_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_last_o,
             occupancy_o
   );

   modport master (
`ifdef REDMULE_EXP_BUF_REPLAY_EN
      output mark_i, rewind_i,
`endif
      output in_valid_i, in_data_i, in_cnt_i, in_last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_last_o,
             occupancy_o
   );
endinterface

// File: rtl/redmule_exp_mc_buffer.sv
// Multi-lane exponent prefetch buffer for the MX datapath. Partially filled
// exponent beats are packed into a power-of-two circular store and handed out
// N_LANES exponents per pop, with tail flushing on in_last_i.
// Optional feature macro: REDMULE_EXP_BUF_REPLAY_EN enables mark/rewind replay,
// where entries between the mark and the read pointer are kept for reuse.
module redmule_exp_mc_buffer #(
   parameter int unsigned EXP_WIDTH  = 8,
   parameter int unsigned BEAT_WIDTH = 512,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned N_LANES    = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   redmule_exp_mc_buffer_if.slave   bus
);
   localparam int unsigned EPB = BEAT_WIDTH / EXP_WIDTH;
   localparam int unsigned ICW = $clog2(EPB + 1);
   localparam int unsigned OCW = $clog2(N_LANES + 1);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned PW  = AW + 1;

   logic [EXP_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]        wptr_q, rptr_q, wptr_n, rptr_n;
   logic                 drain_q, drain_n;
   logic [PW-1:0]        base, used, avail, free_space;
   logic [OCW-1:0]       out_cnt;
   logic                 out_valid, out_last, push, pop;
   logic [AW-1:0]        waddr [EPB];
   logic [N_LANES-1:0][EXP_WIDTH-1:0] lane_data;

`ifdef REDMULE_EXP_BUF_REPLAY_EN
   logic [PW-1:0] mark_q;
   logic          mark_act_q, mark_drain_q;
   logic          do_mark, do_rewind;

   // Rewind only acts on an active mark and beats a simultaneous mark.
   assign do_rewind = bus.rewind_i & mark_act_q;
   assign do_mark   = bus.mark_i & ~bus.rewind_i;
   assign base      = mark_act_q ? mark_q : rptr_q;

   // Replay mark pointer, its active flag and the drain flag seen at mark time.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mark_q       <= '0;
         mark_act_q   <= 1'b0;
         mark_drain_q <= 1'b0;
      end else if (clear_i) begin
         mark_q       <= '0;
         mark_act_q   <= 1'b0;
         mark_drain_q <= 1'b0;
      end else if (do_mark) begin
         mark_q       <= rptr_q;
         mark_act_q   <= 1'b1;
         mark_drain_q <= drain_q;
      end
   end
`else
   assign base = rptr_q;
`endif

   // Space is measured from the oldest protected entry, data from the read pointer.
   assign used       = wptr_q - base;
   assign avail      = wptr_q - rptr_q;
   assign free_space = PW'(DEPTH) - used;

   assign bus.in_ready_o = (free_space >= PW'(EPB));
   assign out_cnt        = (avail >= PW'(N_LANES)) ? OCW'(N_LANES) : OCW'(avail);
   assign out_valid      = (avail >= PW'(N_LANES)) | (drain_q & (avail != '0));
   assign out_last       = drain_q & (avail <= PW'(N_LANES));
   assign push           = bus.in_valid_i & bus.in_ready_o;
   assign pop            = out_valid & bus.out_ready_i;

   assign bus.out_valid_o = out_valid;
   assign bus.out_cnt_o   = out_cnt;
   assign bus.out_last_o  = out_last;
   assign bus.occupancy_o = avail;
   assign bus.out_data_o  = lane_data;

   // Per-exponent write addresses wrap modulo DEPTH; read lanes wrap the same way
   // and lanes past the valid count are forced to zero.
   for (genvar i = 0; i < EPB; i++) begin : g_waddr
      assign waddr[i] = wptr_q[AW-1:0] + AW'(i);
   end

   for (genvar j = 0; j < N_LANES; j++) begin : g_lane
      logic [AW-1:0] raddr;
      assign raddr        = rptr_q[AW-1:0] + AW'(j);
      assign lane_data[j] = (OCW'(j) < out_cnt) ? mem_q[raddr] : '0;
   end

   // Store the valid low exponents of an accepted beat; the rest are left untouched.
   // NOTE: the storage array has no reset; its contents only become visible
   // through pointers that are reset, so clearing it would be wasted logic.
   always_ff @(posedge clk_i) begin
      if (push) begin
         for (int i = 0; i < EPB; i++) begin
            if (ICW'(i) < bus.in_cnt_i) begin
               mem_q[waddr[i]] <= bus.in_data_i[i*EXP_WIDTH +: EXP_WIDTH];
            end
         end
      end
   end

   // Next pointers and drain flag; push and pop both use the pre-edge pointers.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      wptr_n  = wptr_q;
      rptr_n  = rptr_q;
      drain_n = drain_q;
      if (push) wptr_n = wptr_q + PW'(bus.in_cnt_i);
      if (pop)  rptr_n = rptr_q + PW'(out_cnt);
      if (pop && out_last) drain_n = 1'b0;
      if (push && bus.in_last_i) drain_n = 1'b1;
`ifdef REDMULE_EXP_BUF_REPLAY_EN
      if (do_rewind) begin
         rptr_n  = mark_q;
         drain_n = mark_drain_q | (push & bus.in_last_i);
      end
`endif
   end

   // Pointer and drain state with async reset and synchronous clear.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         drain_q <= 1'b0;
      end else if (clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         drain_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_n;
         rptr_q  <= rptr_n;
         drain_q <= drain_n;
      end
   end
endmodule
